// File: rtl/u2_to_zm_arbiter_pkg.sv
// Shared ALU-path definitions for the U2-to-ZM arbiter: FSM states, status codes
// and the requester count.
package u2_to_zm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] ST_OK  = 4'b0000;
    localparam logic [3:0] ST_OVF = 4'b1001;

    localparam int N_CH = 2;

endpackage

// File: rtl/u2_to_zm.sv
// Combinational two's-complement to sign-magnitude converter.
// The most negative operand has no ZM equivalent; it is flagged with ST_OVF.
module u2_to_zm
    import u2_to_zm_arbiter_pkg::*;
#(
    parameter int M = 8,
    parameter int K = 8
) (
    input  logic [M-1:0] i_arg,
    output logic [K-1:0] o_result,
    output logic [3:0]   o_status
);

    logic [M-1:0] res;

    always_comb begin
        res      = i_arg;
        o_status = ST_OK;
        if (i_arg[M-1]) begin
            if (i_arg[M-2:0] == '0) begin
                res      = {1'b1, {(M-1){1'b0}}};
                o_status = ST_OVF;
            end else begin
                res = {1'b1, (~i_arg[M-2:0]) + {{(M-2){1'b0}}, 1'b1}};
            end
        end
    end

    assign o_result = K'(res);

endmodule

// File: rtl/u2_to_zm_arbiter.sv
// Two-channel round-robin front end sharing one U2-to-ZM converter, with a
// tagged valid/ready response port and a saturating error counter.
//   state | meaning
//   IDLE  | offer grant to one channel, latch operand on handshake
//   CONV  | registered operand drives converter, capture result/status/id
//   RESP  | present response, hold until i_rsp_ready
module u2_to_zm_arbiter
    import u2_to_zm_arbiter_pkg::*;
#(
    parameter int M = 8,
    parameter int K = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_CH-1:0]           i_req_valid,
    input  logic [N_CH-1:0][M-1:0]    i_req_arg,
    output logic [N_CH-1:0]           o_req_ready,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [K-1:0]              o_rsp_result,
    output logic [3:0]                o_rsp_status,
    output logic                      o_rsp_id,
    output logic [7:0]                o_err_cnt
);

    state_t       state_q, state_d;
    logic         ptr_q, ptr_d;
    logic [M-1:0] arg_q, arg_d;
    logic         id_q, id_d;
    logic [K-1:0] result_q, result_d;
    logic [3:0]   status_q, status_d;
    logic         rsp_id_q, rsp_id_d;
    logic [7:0]   err_cnt_q, err_cnt_d;

    logic         gnt;
    logic [K-1:0] conv_result;
    logic [3:0]   conv_status;

    u2_to_zm #(.M(M), .K(K)) u_conv (
        .i_arg    (arg_q),
        .o_result (conv_result),
        .o_status (conv_status)
    );

    // Pointer only breaks ties; a lone requester is always served.
    assign gnt = (&i_req_valid) ? ptr_q : i_req_valid[1];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        arg_d       = arg_q;
        id_d        = id_q;
        result_d    = result_q;
        status_d    = status_q;
        rsp_id_d    = rsp_id_q;
        err_cnt_d   = err_cnt_q;
        o_req_ready = '0;

        unique case (state_q)
            IDLE: begin
                o_req_ready[gnt] = i_req_valid[gnt];
                if (i_req_valid[gnt]) begin
                    arg_d   = i_req_arg[gnt];
                    id_d    = gnt;
                    ptr_d   = ~gnt;
                    state_d = CONV;
                end
            end
            CONV: begin
                result_d = conv_result;
                status_d = conv_status;
                rsp_id_d = id_q;
                if (conv_status != ST_OK && err_cnt_q != 8'hFF)
                    err_cnt_d = err_cnt_q + 8'd1;
                state_d = RESP;
            end
            RESP: begin
                if (i_rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            arg_q     <= '0;
            id_q      <= 1'b0;
            result_q  <= '0;
            status_q  <= ST_OK;
            rsp_id_q  <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            arg_q     <= arg_d;
            id_q      <= id_d;
            result_q  <= result_d;
            status_q  <= status_d;
            rsp_id_q  <= rsp_id_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_rsp_valid  = (state_q == RESP);
    assign o_rsp_result = result_q;
    assign o_rsp_status = status_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_err_cnt    = err_cnt_q;

endmodule
